// File: rtl/exc_vector_ctrl_pkg.sv
// Shared cause codes, vector addresses and sequencer state encoding for the exception block.
// Pure definitions: no latency, no flow control.
package exc_vector_ctrl_pkg;

    localparam logic [1:0] CAUSE_OPCODE = 2'b00;
    localparam logic [1:0] CAUSE_OVF    = 2'b01;
    localparam logic [1:0] CAUSE_DIV0   = 2'b10;

    localparam logic [7:0] VEC_OPCODE   = 8'd253;
    localparam logic [7:0] VEC_OVF      = 8'd254;
    localparam logic [7:0] VEC_DIV0     = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // The mux select and the vector address are related by a fixed offset.
    function automatic logic [7:0] cause_to_vec(input logic [1:0] cause);
        return VEC_OPCODE + {6'd0, cause};
    endfunction

endpackage

// File: rtl/exc_vector_ctrl_prio.sv
// Combinational exception priority encoder: opcode > overflow > divzero.
// Zero latency; no backpressure.
module exc_priority_enc
    import exc_vector_ctrl_pkg::*;
(
    input  logic       i_opcode,
    input  logic       i_ovf,
    input  logic       i_div0,
    output logic [1:0] o_cause,
    output logic       o_vld
);

    always_comb begin
        o_vld   = i_opcode | i_ovf | i_div0;
        o_cause = CAUSE_OPCODE;
        if (i_opcode) begin
            o_cause = CAUSE_OPCODE;
        end else if (i_ovf) begin
            o_cause = CAUSE_OVF;
        end else if (i_div0) begin
            o_cause = CAUSE_DIV0;
        end
    end

endmodule

// File: rtl/exc_vector_ctrl.sv
// Exception sequencer: latch cause/EPC, fetch the handler byte via req/ack, load PC; also EPC->PC on eret.
// pc_wr 2 cycles after detection plus ack wait; stalls the datapath while active, bus_fault on ack timeout.
module exc_vector_ctrl
    import exc_vector_ctrl_pkg::*;
#(
    parameter int PC_OFFSET   = 4,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic        eret,
    input  logic [31:0] pc,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [1:0]  controle,
    output logic        mem_rd,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic [31:0] pc_new,
    output logic        pc_wr,
    output logic        stall,
    output logic        bus_fault
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [31:0]      EPC_OFS  = 32'(PC_OFFSET);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_cause;
    logic [1:0]        r_controle;
    logic [31:0]       r_epc;
    logic [31:0]       r_pc_new;
    logic              r_eret_wr;
    logic              r_bus_fault;

    logic [1:0]        w_exc_cause;
    logic              w_exc_vld;
    logic              w_enter_req;
    logic              w_eret_take;
    logic              w_ack_take;
    logic              w_timeout;
    logic              w_mem_rd;
    logic              w_load_wr;
    logic              w_stall;

    exc_priority_enc u_prio (
        .i_opcode (exc_opcode),
        .i_ovf    (exc_overflow),
        .i_div0   (exc_divzero),
        .o_cause  (w_exc_cause),
        .o_vld    (w_exc_vld)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_enter_req  = 1'b0;
        w_eret_take  = 1'b0;
        w_ack_take   = 1'b0;
        w_timeout    = 1'b0;
        w_mem_rd     = 1'b0;
        w_load_wr    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // An exception in the same cycle as eret wins; eret is dropped.
                if (w_exc_vld) begin
                    w_enter_req  = 1'b1;
                    w_next_state = ST_REQ;
                end else if (eret) begin
                    w_eret_take  = 1'b1;
                end
            end
            ST_REQ: begin
                w_mem_rd = 1'b1;
                w_stall  = 1'b1;
                if (mem_ack) begin
                    w_ack_take   = 1'b1;
                    w_next_state = ST_LOAD;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_load_wr    = 1'b1;
                w_stall      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_cause     <= CAUSE_OPCODE;
            r_controle  <= CAUSE_OPCODE;
            r_epc       <= '0;
            r_pc_new    <= '0;
            r_eret_wr   <= 1'b0;
            r_bus_fault <= 1'b0;
        end else begin
            r_eret_wr <= w_eret_take;
            if (w_enter_req) begin
                r_cause    <= w_exc_cause;
                r_controle <= w_exc_cause;
                r_epc      <= pc - EPC_OFS;
            end
            if (w_eret_take) begin
                r_pc_new <= r_epc;
            end
            if (w_ack_take) begin
                r_pc_new <= {24'd0, mem_data};
            end
            if (w_timeout) begin
                r_bus_fault <= 1'b1;
            end
            // Counter restarts at zero on every REQ entry.
            if (r_state == ST_REQ && !w_ack_take && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // State-decoded strobes fall as soon as reset clears the state register.
    assign mem_rd    = w_mem_rd;
    assign stall     = w_stall;
    assign pc_wr     = w_load_wr | r_eret_wr;
    assign controle  = r_controle;
    assign cause     = r_cause;
    assign epc       = r_epc;
    assign pc_new    = r_pc_new;
    assign bus_fault = r_bus_fault;

endmodule

// File: tb/tb_exc_vector_ctrl.sv
// Randomised bench for exc_vector_ctrl: each exception/eret transaction is predicted from the block's rules
// (priority, EPC arithmetic, ack-delay to pulse counts) and compared at transaction level.
module tb_exc_vector_ctrl;

    localparam int ACK_TIMEOUT = 15;
    localparam int PC_OFFSET   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_divzero, eret;
    logic [31:0] pc;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [1:0]  controle;
    logic        mem_rd;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] pc_new;
    logic        pc_wr;
    logic        stall;
    logic        bus_fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_epc;
    logic [31:0] m_pc_new;
    logic [1:0]  m_cause;
    logic        m_bus_fault;

    exc_vector_ctrl #(
        .PC_OFFSET   (PC_OFFSET),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_divzero  (exc_divzero),
        .eret         (eret),
        .pc           (pc),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .controle     (controle),
        .mem_rd       (mem_rd),
        .epc          (epc),
        .cause        (cause),
        .pc_new       (pc_new),
        .pc_wr        (pc_wr),
        .stall        (stall),
        .bus_fault    (bus_fault)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] prio_cause(input logic [2:0] bits);
        // bits = {divzero, overflow, opcode}
        if (bits[0]) return 2'b00;
        if (bits[1]) return 2'b01;
        return 2'b10;
    endfunction

    task automatic clear_inputs();
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_divzero = 1'b0;
        eret = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic model_reset();
        m_epc = '0; m_pc_new = '0; m_cause = '0; m_bus_fault = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_mem_rd"},    {31'd0, mem_rd},    32'd0);
        check_eq({pfx, "_pc_wr"},     {31'd0, pc_wr},     32'd0);
        check_eq({pfx, "_stall"},     {31'd0, stall},     32'd0);
        check_eq({pfx, "_epc"},       epc,                32'd0);
        check_eq({pfx, "_cause"},     {30'd0, cause},     32'd0);
        check_eq({pfx, "_controle"},  {30'd0, controle},  32'd0);
        check_eq({pfx, "_pc_new"},    pc_new,             32'd0);
        check_eq({pfx, "_bus_fault"}, {31'd0, bus_fault}, 32'd0);
    endtask

    // delay = number of REQ cycles without ack before the ack; delay >= ACK_TIMEOUT means no ack.
    task automatic run_exc(input logic [31:0] p, input logic [2:0] bits, input int delay,
                           input logic [7:0] data, input logic with_eret);
        logic [1:0]  exp_cause;
        logic        to;
        int          n_rd, n_stall, n_wr, wr_k, bad_ctl;
        logic [31:0] wr_val;
        exp_cause = prio_cause(bits);
        to = (delay >= ACK_TIMEOUT);
        n_rd = 0; n_stall = 0; n_wr = 0; wr_k = -1; bad_ctl = 0; wr_val = '0;

        @(negedge clock);
        pc = p;
        {exc_divzero, exc_overflow, exc_opcode} = bits;
        eret = with_eret;
        mem_ack = 1'b0;
        m_epc   = p - 32'(PC_OFFSET);
        m_cause = exp_cause;

        for (int k = 1; k <= 22; k++) begin
            @(negedge clock);
            if (mem_rd) begin
                n_rd++;
                if (controle !== exp_cause) bad_ctl++;
            end
            if (stall) n_stall++;
            if (pc_wr) begin
                n_wr++;
                wr_k = k;
                wr_val = pc_new;
            end
            clear_inputs();
            pc = $urandom;
            if (!to && k == delay + 1) begin
                mem_ack  = 1'b1;
                mem_data = data;
            end else begin
                mem_data = 8'($urandom);
            end
        end
        mem_ack = 1'b0;

        if (to) begin
            m_bus_fault = 1'b1;
            check_eq("to_mem_rd_cycles", n_rd, ACK_TIMEOUT);
            check_eq("to_stall_cycles", n_stall, ACK_TIMEOUT);
            check_eq("to_pc_wr_pulses", n_wr, 0);
        end else begin
            m_pc_new = {24'd0, data};
            check_eq("mem_rd_cycles", n_rd, delay + 1);
            check_eq("stall_cycles", n_stall, delay + 2);
            check_eq("pc_wr_pulses", n_wr, 1);
            check_eq("pc_wr_latency", wr_k, delay + 2);
            check_eq("pc_new_at_wr", wr_val, {24'd0, data});
        end
        check_eq("controle_in_req", bad_ctl, 0);
        check_eq("controle_held", {30'd0, controle}, {30'd0, exp_cause});
        check_eq("cause", {30'd0, cause}, {30'd0, m_cause});
        check_eq("epc", epc, m_epc);
        check_eq("pc_new", pc_new, m_pc_new);
        check_eq("bus_fault", {31'd0, bus_fault}, {31'd0, m_bus_fault});
    endtask

    task automatic run_eret();
        int          n_wr, n_stall;
        logic [31:0] wr_val;
        n_wr = 0; n_stall = 0; wr_val = '0;
        @(negedge clock);
        clear_inputs();
        eret = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            eret = 1'b0;
            if (pc_wr) begin
                n_wr++;
                wr_val = pc_new;
            end
            if (stall) n_stall++;
        end
        m_pc_new = m_epc;
        check_eq("eret_pc_wr_pulses", n_wr, 1);
        check_eq("eret_pc_new", wr_val, m_epc);
        check_eq("eret_stall", n_stall, 0);
    endtask

    task automatic idle_gap(input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (mem_rd || pc_wr || stall) bad++;
            clear_inputs();
            mem_ack  = 1'($urandom);
            mem_data = 8'($urandom);
            pc       = $urandom;
        end
        @(negedge clock);
        if (mem_rd || pc_wr || stall) bad++;
        mem_ack = 1'b0;
        check_eq("idle_quiet", bad, 0);
    endtask

    task automatic reset_mid_req();
        @(negedge clock);
        pc = 32'h0000_1234;
        exc_divzero = 1'b1;
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        check_eq("pre_rst_mem_rd", {31'd0, mem_rd}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all_zero("mid_rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        pc = '0;
        mem_data = '0;
        model_reset();
        #1;
        check_all_zero("rst");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_exc(32'h0000_0040, 3'b010, 2, 8'h80, 1'b0);
        run_eret();
        idle_gap(2);
        run_exc(32'h0000_0100, 3'b111, 0, 8'h11, 1'b0);
        run_exc(32'h0000_0200, 3'b100, ACK_TIMEOUT + 5, 8'h00, 1'b0);
        run_exc(32'h0000_0000, 3'b010, 1, 8'h22, 1'b1);
        run_eret();
        reset_mid_req();
        run_exc(32'h0000_0300, 3'b100, 0, 8'h33, 1'b0);
        run_exc(32'h0000_0400, 3'b001, ACK_TIMEOUT - 1, 8'h44, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int d;
            idle_gap($urandom_range(0, 3));
            d = $urandom_range(0, 20);
            run_exc($urandom, 3'($urandom_range(1, 7)), d, 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) run_eret();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
